tlc_sensor_if: RTL
==================

Name: tlc_sensor_if

Overview:
- Front end that drives the traffic light controller's car-sensor inputs (FS farm road, HS highway) from raw, asynchronous, bouncy detector pins.
- Synchronizes and debounces each pin, then latches a car request.
- Holds the request on FS/HS until the controller's LED output shows that road being served, then clears it and pulses an acknowledge.
- Sits between the board detector pins and the controller; also reads the controller's LED bus.

Parameters:
- DEB_CYCLES, 2, consecutive clocks a synchronized pin must differ from its debounced state before that state flips; legal range 1..255.
- F_SRV_MASK, 7'h7F, bits of LED_IN[6:0] compared when detecting farm-road service.
- F_SRV_VAL, 7'b1000001, LED_IN[6:0] pattern (after mask) meaning farm road is being served.
- H_SRV_MASK, 7'h7F, bits of LED_IN[6:0] compared when detecting highway service.
- H_SRV_VAL, 7'b0010100, LED_IN[6:0] pattern (after mask) meaning highway is being served.

Ports:
- MCLK  input  1  system clock; all state changes on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- F_RAW  input  1  raw farm-road car detector; asynchronous, may bounce.
- H_RAW  input  1  raw highway car detector; asynchronous, may bounce.
- LED_IN  input  8  controller LED bus; only bits [6:0] are used, bit 7 is ignored.
- FS  output  1  latched farm-road request to the controller.
- HS  output  1  latched highway request to the controller.
- F_ACK  output  1  one-cycle pulse when the farm request clears.
- H_ACK  output  1  one-cycle pulse when the highway request clears.

Behaviour:
- One clock (MCLK); reset is asynchronous and active-high (RESET). While RESET is high, every flop and output is 0: sync stages, debounced state, counters, FS, HS, F_ACK, H_ACK, and wait counters if present. This applies mid-operation too: pending requests are dropped, not remembered.
- Each road has an identical, independent channel. Farm: F_RAW, FS, F_ACK, F_SRV_*. Highway: H_RAW, HS, H_ACK, H_SRV_*.
- Sync: two-flop synchronizer s1 -> s2.
- Debounce: counter cnt, width clog2(DEB_CYCLES)+1.
  - At each edge, if s2 == deb: cnt <= 0.
  - Else if cnt == DEB_CYCLES-1: deb <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any bounce back (s2 == deb) restarts the count.
- Set event: at the edge where deb changes 0->1. Falling deb has no effect on the request.
- Serve event: at an edge where the request is 1 and (LED_IN[6:0] & MASK) == VAL.
- Request register (drives FS/HS):
  - Set event: request <= 1.
  - Serve event with no set event on the same edge: request <= 0 and ACK <= 1 for exactly one cycle.
  - Set and serve on the same edge: set wins, request stays 1, ACK stays 0.
  - ACK is 0 on every other cycle.
- Latency: raw change captured at edge e0 -> s2 at e1 -> deb and FS/HS at e(1+DEB_CYCLES). Default: FS rises 3 edges after F_RAW is sampled high.
- The serve pattern present while the request is 0 has no effect and produces no ACK.
- A new car arriving while the request is already 1 is absorbed (no counting). After a clear, a new rising deb re-arms the request.
- A pin held high through its own serve phase does not re-request. A fresh 0->1 deb transition is required.

Optional Feature:
- Macro: TLC_SENSOR_WAITCNT_EN.
- Defined: adds two output ports, F_WAIT[7:0] and H_WAIT[7:0].
  - Each clears to 0 on its set event.
  - Increments by 1 every cycle its request is 1, saturating at 255.
  - Holds its value after the serve clear until the next set event.
  - Reset value is 0.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset check: RESET=1 for 2 cycles, F_RAW=H_RAW=1 throughout -> FS=HS=F_ACK=H_ACK=0 during reset; after release, FS=HS=1 by edge 3.
- Farm request and serve: F_RAW pulse high 4 cycles (DEB_CYCLES=2) -> FS=1 at edge 3 and stays 1 after F_RAW drops. Drive LED_IN=8'b01000001 -> FS=0 and F_ACK=1 for exactly 1 cycle on that edge.
- Bounce rejection: H_RAW toggles 1,0,1,0 each cycle -> HS stays 0. Then hold H_RAW=1 -> HS=1 after 3 edges. LED_IN=8'b00010100 clears HS with an H_ACK pulse.
- Both roads: F_RAW=H_RAW=1 together -> FS and HS rise on the same edge. Highway serve pattern clears only HS; farm pattern later clears FS; the ACK pulses are on separate cycles.
- Simultaneous set and serve: arrange the deb 0->1 edge to coincide with LED_IN=F_SRV_VAL while FS=1 -> FS stays 1, F_ACK=0.
- Mid-operation reset and waitcnt: FS pending, assert RESET asynchronously mid-cycle -> FS=0 immediately. With TLC_SENSOR_WAITCNT_EN, hold a request 300 cycles -> F_WAIT saturates at 255, then holds after the serve clear.

Source files
------------

// File: rtl/tlc_sensor_if_if.sv
// ---------------------------------------------------------------------------
// tlc_sensor_if_if
// Bundles the car-sensor front end's pin, LED and request signals.
//   F_RAW, H_RAW : raw asynchronous car detector pins (farm, highway)
//   LED_IN[7:0]  : controller LED bus; only bits [6:0] carry meaning
//   FS, HS       : latched car requests toward the controller
//   F_ACK, H_ACK : one-cycle pulses when a request is cleared by service
//   F_WAIT, H_WAIT [7:0] : request wait counters, present only when
//                  TLC_SENSOR_WAITCNT_EN is defined
// Modports:
//   slave  : the sensor front end (reads pins/LEDs, drives requests)
//   master : the surrounding board/controller side
// ---------------------------------------------------------------------------
interface tlc_sensor_if_if;
  logic       F_RAW;
  logic       H_RAW;
  logic [7:0] LED_IN;
  logic       FS;
  logic       HS;
  logic       F_ACK;
  logic       H_ACK;
`ifdef TLC_SENSOR_WAITCNT_EN
  logic [7:0] F_WAIT;
  logic [7:0] H_WAIT;

  modport slave (
    input  F_RAW, H_RAW, LED_IN,
    output FS, HS, F_ACK, H_ACK, F_WAIT, H_WAIT
  );

  modport master (
    output F_RAW, H_RAW, LED_IN,
    input  FS, HS, F_ACK, H_ACK, F_WAIT, H_WAIT
  );
`else
  modport slave (
    input  F_RAW, H_RAW, LED_IN,
    output FS, HS, F_ACK, H_ACK
  );

  modport master (
    output F_RAW, H_RAW, LED_IN,
    input  FS, HS, F_ACK, H_ACK
  );
`endif
endinterface

// File: rtl/tlc_sensor_if.sv
// ---------------------------------------------------------------------------
// tlc_sensor_if
// Car-sensor front end for the traffic light controller. Each road (farm,
// highway) has an independent channel: two-flop synchronizer, debounce
// counter, and a request latch that sets on a debounced rising edge and
// clears (with a one-cycle acknowledge) once the controller LEDs show that
// road being served.
// Ports:
//   MCLK  : system clock, rising edge
//   RESET : asynchronous active-high reset, clears every flop
//   bus   : tlc_sensor_if_if.slave (F_RAW, H_RAW, LED_IN in;
//           FS, HS, F_ACK, H_ACK out; F_WAIT, H_WAIT out when enabled)
// Optional feature macro: TLC_SENSOR_WAITCNT_EN adds saturating 8-bit wait
// counters per road (cleared on set, count while requesting, hold after).
// Channel index 0 = farm road, 1 = highway.
// ---------------------------------------------------------------------------
module tlc_sensor_if #(
  parameter int unsigned DEB_CYCLES = 2,
  parameter logic [6:0]  F_SRV_MASK = 7'h7F,
  parameter logic [6:0]  F_SRV_VAL  = 7'b1000001,
  parameter logic [6:0]  H_SRV_MASK = 7'h7F,
  parameter logic [6:0]  H_SRV_VAL  = 7'b0010100
) (
  input logic            MCLK,
  input logic            RESET,
  tlc_sensor_if_if.slave bus
);

  localparam int unsigned CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]         raw_s;
  logic [1:0]         srv_s;
  logic [1:0]         set_s;
  logic [1:0]         serve_s;
  logic               led_unused;

  logic [1:0]         s1_q, s1_d;
  logic [1:0]         s2_q, s2_d;
  logic [1:0]         deb_q, deb_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         req_q, req_d;
  logic [1:0]         ack_q, ack_d;
`ifdef TLC_SENSOR_WAITCNT_EN
  logic [1:0][7:0]    wait_q, wait_d;
`endif

  assign raw_s      = {bus.H_RAW, bus.F_RAW};
  // LED bit 7 has no meaning for service detection
  assign led_unused = bus.LED_IN[7];
  assign srv_s[0]   = ((bus.LED_IN[6:0] & F_SRV_MASK) == F_SRV_VAL);
  assign srv_s[1]   = ((bus.LED_IN[6:0] & H_SRV_MASK) == H_SRV_VAL);

  // Next-state logic for both channels: sync, debounce, request latch
  always_comb begin
    s1_d    = raw_s;
    s2_d    = s1_q;
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    ack_d   = 2'b00;
    set_s   = 2'b00;
    serve_s = 2'b00;
`ifdef TLC_SENSOR_WAITCNT_EN
    wait_d  = wait_q;
`endif
    for (int ch = 0; ch < 2; ch++) begin
      // Any bounce back to the debounced level restarts the qualification
      if (s2_q[ch] == deb_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == CNT_LAST) begin
        deb_d[ch] = s2_q[ch];
        cnt_d[ch] = '0;
      end else begin
        cnt_d[ch] = cnt_q[ch] + {{(CW-1){1'b0}}, 1'b1};
      end

      set_s[ch]   = ~deb_q[ch] & deb_d[ch];
      serve_s[ch] = req_q[ch] & srv_s[ch];

      // A fresh car on the serve edge keeps the request alive, no ack
      if (set_s[ch]) begin
        req_d[ch] = 1'b1;
      end else if (serve_s[ch]) begin
        req_d[ch] = 1'b0;
        ack_d[ch] = 1'b1;
      end else begin
        req_d[ch] = req_q[ch];
      end

`ifdef TLC_SENSOR_WAITCNT_EN
      if (set_s[ch]) begin
        wait_d[ch] = 8'd0;
      end else if (req_q[ch] && (wait_q[ch] != 8'd255)) begin
        wait_d[ch] = wait_q[ch] + 8'd1;
      end else begin
        wait_d[ch] = wait_q[ch];
      end
`endif
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      s1_q   <= 2'b00;
      s2_q   <= 2'b00;
      deb_q  <= 2'b00;
      cnt_q  <= '0;
      req_q  <= 2'b00;
      ack_q  <= 2'b00;
`ifdef TLC_SENSOR_WAITCNT_EN
      wait_q <= '0;
`endif
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
      req_q  <= req_d;
      ack_q  <= ack_d;
`ifdef TLC_SENSOR_WAITCNT_EN
      wait_q <= wait_d;
`endif
    end
  end

  assign bus.FS    = req_q[0];
  assign bus.HS    = req_q[1];
  assign bus.F_ACK = ack_q[0];
  assign bus.H_ACK = ack_q[1];
`ifdef TLC_SENSOR_WAITCNT_EN
  assign bus.F_WAIT = wait_q[0];
  assign bus.H_WAIT = wait_q[1];
`endif

endmodule
